mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Memory front end: arbitrates a CPU data port and an instruction-fetch port
// over two external SRAM banks and a UART that shares the bank-1 bus.
module mem_arbiter #(
  parameter int unsigned       DATA_W         = 16,
  parameter int unsigned       ADDR_W         = 18,
  parameter int unsigned       PC_W           = 16,
  parameter logic [ADDR_W-1:0] SPLIT_ADDR     = 18'h08000,
  parameter logic [ADDR_W-1:0] UART_DATA_ADDR = 18'h0BF00,
  parameter logic [ADDR_W-1:0] UART_STAT_ADDR = 18'h0BF01,
  parameter int unsigned       WAIT_CYCLES    = 1
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              en,
  input  logic              op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ack,
  output logic              ram_pause,
  input  logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] sram1_addr,
  output logic [DATA_W-1:0] sram1_dq_o,
  input  logic [DATA_W-1:0] sram1_dq_i,
  output logic              sram1_dq_t,
  output logic              sram1_ce_n,
  output logic              sram1_oe_n,
  output logic              sram1_we_n,
  output logic [ADDR_W-1:0] sram2_addr,
  output logic [DATA_W-1:0] sram2_dq_o,
  input  logic [DATA_W-1:0] sram2_dq_i,
  output logic              sram2_dq_t,
  output logic              sram2_ce_n,
  output logic              sram2_oe_n,
  output logic              sram2_we_n,
  input  logic              tsre,
  input  logic              tbre,
  input  logic              data_ready,
  output logic              rdn,
  output logic              wrn
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, U_WAIT, U_STROBE, U_STAT} state_t;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  state_t            state_reg;
  logic [2:0]        cnt_reg;
  logic              op_reg, bank1_reg, own2_reg, run_reg, ack_reg;
  logic              rdn_reg, wrn_reg;
  logic [DATA_W-1:0] data_o_reg;
  logic [ADDR_W-1:0] addr1_reg, addr2_reg;
  logic [DATA_W-1:0] dq1_reg, dq2_reg;
  logic              dq_t1_reg, ce1_n_reg, oe1_n_reg, we1_n_reg;
  logic              dq_t2_reg, ce2_n_reg, oe2_n_reg, we2_n_reg;
  logic              fetch;

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      op_reg     <= 1'b0;
      bank1_reg  <= 1'b0;
      own2_reg   <= 1'b0;
      run_reg    <= 1'b0;
      ack_reg    <= 1'b0;
      rdn_reg    <= 1'b1;
      wrn_reg    <= 1'b1;
      data_o_reg <= '0;
      addr1_reg  <= '0;
      addr2_reg  <= '0;
      dq1_reg    <= '0;
      dq2_reg    <= '0;
      dq_t1_reg  <= 1'b1;
      ce1_n_reg  <= 1'b1;
      oe1_n_reg  <= 1'b1;
      we1_n_reg  <= 1'b1;
      dq_t2_reg  <= 1'b1;
      ce2_n_reg  <= 1'b1;
      oe2_n_reg  <= 1'b1;
      we2_n_reg  <= 1'b1;
    end else begin
      run_reg <= 1'b1;
      ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (en) begin
            op_reg <= op;
            if (addr == UART_DATA_ADDR) begin
              state_reg <= U_WAIT;
            end else if (addr == UART_STAT_ADDR) begin
              state_reg  <= U_STAT;
              data_o_reg <= DATA_W'({data_ready, tsre & tbre});
              ack_reg    <= 1'b1;
            end else begin
              state_reg <= SETUP;
              bank1_reg <= (addr >= SPLIT_ADDR);
              if (addr < SPLIT_ADDR) begin
                own2_reg  <= 1'b1;
                addr2_reg <= addr;
                ce2_n_reg <= 1'b0;
                oe2_n_reg <= op;
                dq_t2_reg <= ~op;
                dq2_reg   <= data_i;
              end else begin
                addr1_reg <= addr;
                ce1_n_reg <= 1'b0;
                oe1_n_reg <= op;
                dq_t1_reg <= ~op;
                dq1_reg   <= data_i;
              end
            end
          end
        end
        SETUP: begin
          state_reg <= STROBE;
          cnt_reg   <= WAIT_INIT;
          if (op_reg) begin
            if (bank1_reg) we1_n_reg <= 1'b0;
            else           we2_n_reg <= 1'b0;
          end
        end
        STROBE: begin
          if (cnt_reg == 3'd0) begin
            state_reg <= HOLD;
            ack_reg   <= 1'b1;
            we1_n_reg <= 1'b1;
            we2_n_reg <= 1'b1;
            if (!op_reg) data_o_reg <= bank1_reg ? sram1_dq_i : sram2_dq_i;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        HOLD: begin
          // Write data and address were held through this cycle; release the bus now.
          state_reg <= IDLE;
          own2_reg  <= 1'b0;
          dq_t1_reg <= 1'b1;
          ce1_n_reg <= 1'b1;
          oe1_n_reg <= 1'b1;
          dq_t2_reg <= 1'b1;
          ce2_n_reg <= 1'b1;
          oe2_n_reg <= 1'b1;
        end
        U_WAIT: begin
          if (op_reg ? (tsre & tbre) : data_ready) begin
            state_reg <= U_STROBE;
            cnt_reg   <= WAIT_INIT;
            if (op_reg) begin
              wrn_reg   <= 1'b0;
              dq_t1_reg <= 1'b0;
              dq1_reg   <= data_i;
            end else begin
              rdn_reg <= 1'b0;
            end
          end
        end
        U_STROBE: begin
          if (cnt_reg == 3'd0) begin
            state_reg <= HOLD;
            ack_reg   <= 1'b1;
            rdn_reg   <= 1'b1;
            wrn_reg   <= 1'b1;
            if (!op_reg) data_o_reg <= sram1_dq_i;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        U_STAT:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Fetch owns bank 2 whenever no data access has claimed it.
  assign fetch = run_reg & ~own2_reg;

  assign ram_pause  = en & ~ack_reg;
  assign ack        = ack_reg;
  assign data_o     = data_o_reg;
  assign rdn        = rdn_reg;
  assign wrn        = wrn_reg;

  assign sram1_addr = addr1_reg;
  assign sram1_dq_o = dq1_reg;
  assign sram1_dq_t = dq_t1_reg;
  assign sram1_ce_n = ce1_n_reg;
  assign sram1_oe_n = oe1_n_reg;
  assign sram1_we_n = we1_n_reg;

  assign sram2_addr = fetch ? ADDR_W'(pc) : addr2_reg;
  assign sram2_dq_o = dq2_reg;
  assign sram2_dq_t = fetch ? 1'b1 : dq_t2_reg;
  assign sram2_ce_n = fetch ? 1'b0 : ce2_n_reg;
  assign sram2_oe_n = fetch ? 1'b0 : oe2_n_reg;
  assign sram2_we_n = fetch ? 1'b1 : we2_n_reg;

  assign inst       = fetch ? sram2_dq_i : '0;
  assign inst_valid = fetch;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: SRAM/UART pin models plus a
// transaction-level scoreboard of expected memory contents and latencies.
module tb_mem_arbiter;

  localparam int WAIT = 1;

  logic        clk_50MHz = 1'b0;
  logic        rst, en, op;
  logic [17:0] addr;
  logic [15:0] data_i, data_o, inst;
  logic        ack, ram_pause, inst_valid;
  logic [15:0] pc;
  logic [17:0] sram1_addr, sram2_addr;
  logic [15:0] sram1_dq_o, sram1_dq_i, sram2_dq_o, sram2_dq_i;
  logic        sram1_dq_t, sram1_ce_n, sram1_oe_n, sram1_we_n;
  logic        sram2_dq_t, sram2_ce_n, sram2_oe_n, sram2_we_n;
  logic        tsre, tbre, data_ready, rdn, wrn;

  logic [15:0] mem1 [16];
  logic [15:0] mem2 [16];
  logic [15:0] ref1 [16];
  logic [15:0] ref2 [16];
  logic [15:0] uart_rx, uart_tx;
  logic        load;
  int          vectors = 0;
  int          errors  = 0;

  mem_arbiter #(.WAIT_CYCLES(WAIT)) dut (
    .clk_50MHz(clk_50MHz), .rst(rst), .en(en), .op(op), .addr(addr),
    .data_i(data_i), .data_o(data_o), .ack(ack), .ram_pause(ram_pause),
    .pc(pc), .inst(inst), .inst_valid(inst_valid),
    .sram1_addr(sram1_addr), .sram1_dq_o(sram1_dq_o), .sram1_dq_i(sram1_dq_i),
    .sram1_dq_t(sram1_dq_t), .sram1_ce_n(sram1_ce_n), .sram1_oe_n(sram1_oe_n),
    .sram1_we_n(sram1_we_n),
    .sram2_addr(sram2_addr), .sram2_dq_o(sram2_dq_o), .sram2_dq_i(sram2_dq_i),
    .sram2_dq_t(sram2_dq_t), .sram2_ce_n(sram2_ce_n), .sram2_oe_n(sram2_oe_n),
    .sram2_we_n(sram2_we_n),
    .tsre(tsre), .tbre(tbre), .data_ready(data_ready), .rdn(rdn), .wrn(wrn)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  // Pin-level device models: SRAMs are 16 words deep (low address bits), UART shares bank 1.
  assign sram1_dq_i = !rdn ? uart_rx :
                      (!sram1_ce_n && !sram1_oe_n) ? mem1[sram1_addr[3:0]] : 16'hDEAD;
  assign sram2_dq_i = (!sram2_ce_n && !sram2_oe_n) ? mem2[sram2_addr[3:0]] : 16'hDEAD;

  always @(posedge clk_50MHz) begin
    if (load) begin
      mem1 <= ref1;
      mem2 <= ref2;
    end else begin
      if (!sram1_ce_n && !sram1_we_n && !sram1_dq_t) mem1[sram1_addr[3:0]] <= sram1_dq_o;
      if (!sram2_ce_n && !sram2_we_n && !sram2_dq_t) mem2[sram2_addr[3:0]] <= sram2_dq_o;
    end
    if (!wrn && !sram1_dq_t) uart_tx <= sram1_dq_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // kind: 0 bank write, 1 bank read, 2 UART write, 3 UART read, 4 status read, 5 status write.
  // k: UART not-ready cycles for kinds 2/3; {data_ready,tsre,tbre} for kinds 4/5.
  task automatic run_txn(input int kind, input logic [17:0] a, input logic [15:0] d, input int k);
    int          lat, c, we1, we2, oe1, nrd, nwr;
    bit          b2, done, is_wr;
    logic [15:0] exp_d;
    logic [2:0]  fl;
    b2    = (kind < 2) && (a < 18'h08000);
    is_wr = (kind == 0) || (kind == 2) || (kind == 5);
    fl    = 3'(k);
    en = 1'b1; op = is_wr; addr = a; data_i = d; pc = 16'($urandom);
    uart_rx = 16'($urandom);
    tsre = 1'($urandom); tbre = 1'($urandom); data_ready = 1'($urandom);
    if (kind == 2) tbre = 1'b0;
    if (kind == 3) data_ready = 1'b0;
    if (kind >= 4) begin
      data_ready = fl[2]; tsre = fl[1]; tbre = fl[0];
    end
    exp_d = 16'h0000;
    if (kind == 1) exp_d = b2 ? ref2[a[3:0]] : ref1[a[3:0]];
    if (kind == 3) exp_d = uart_rx;
    if (kind >= 4) exp_d = {14'd0, data_ready, tsre & tbre};
    lat = (kind >= 4) ? 1 : WAIT + 3 + ((kind == 2 || kind == 3) ? k : 0);
    #1 check("pause_c0", {31'd0, ram_pause}, 1);
    c = 0; done = 0; we1 = 0; we2 = 0; oe1 = 0; nrd = 0; nwr = 0;
    while (!done && c < lat + 20) begin
      @(posedge clk_50MHz);
      @(negedge clk_50MHz);
      c++;
      if (!sram1_we_n) we1++;
      if (!sram2_we_n) we2++;
      if (!sram1_ce_n && !sram1_oe_n) oe1++;
      if (!rdn) nrd++;
      if (!wrn) nwr++;
      check("inst_valid", {31'd0, inst_valid}, {31'd0, !b2});
      check("inst", {16'd0, inst}, b2 ? 32'd0 : {16'd0, ref2[pc[3:0]]});
      if (ack) begin
        done = 1;
        check("latency", c, lat);
        check("pause_ack", {31'd0, ram_pause}, 0);
        if (!is_wr) check("data_o", {16'd0, data_o}, {16'd0, exp_d});
        en = 1'b0;
      end else begin
        check("pause", {31'd0, ram_pause}, 1);
      end
      pc = 16'($urandom);
      if (kind == 2 && c > k) begin tsre = 1'b1; tbre = 1'b1; end
      if (kind == 3 && c > k) data_ready = 1'b1;
    end
    check("ack_seen", {31'd0, done}, 1);
    check("we1_cycles", we1, (kind == 0 && !b2) ? WAIT + 1 : 0);
    check("we2_cycles", we2, (kind == 0 && b2) ? WAIT + 1 : 0);
    check("oe1_cycles", oe1, (kind == 1 && !b2) ? WAIT + 3 : 0);
    check("rdn_cycles", nrd, (kind == 3) ? WAIT + 1 : 0);
    check("wrn_cycles", nwr, (kind == 2) ? WAIT + 1 : 0);
    if (kind == 2) check("uart_tx", {16'd0, uart_tx}, {16'd0, d});
    if (kind == 0) begin
      if (b2) ref2[a[3:0]] = d;
      else    ref1[a[3:0]] = d;
    end
    $display("txn kind=%0d addr=%h data=%h k=%0d lat=%0d cycles=%0d", kind, a, d, k, lat, c);
    @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    check("idle_valid", {31'd0, inst_valid}, 1);
    check("idle_inst", {16'd0, inst}, {16'd0, ref2[pc[3:0]]});
  endtask

  initial begin
    int          kind, k;
    logic [17:0] a;
    logic [3:0]  idx;
    rst = 1'b1; en = 1'b1; op = 1'b1; addr = 18'h00100; data_i = 16'hA5A5; pc = 16'd0;
    tsre = 1'b0; tbre = 1'b0; data_ready = 1'b0; uart_rx = 16'd0; load = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ref1[i] = 16'($urandom);
      ref2[i] = 16'($urandom);
    end
    @(negedge clk_50MHz);
    load = 1'b0;
    @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    check("rst_ce1", {31'd0, sram1_ce_n}, 1);
    check("rst_oe1", {31'd0, sram1_oe_n}, 1);
    check("rst_we1", {31'd0, sram1_we_n}, 1);
    check("rst_ce2", {31'd0, sram2_ce_n}, 1);
    check("rst_oe2", {31'd0, sram2_oe_n}, 1);
    check("rst_we2", {31'd0, sram2_we_n}, 1);
    check("rst_rdn", {31'd0, rdn}, 1);
    check("rst_wrn", {31'd0, wrn}, 1);
    check("rst_dqt1", {31'd0, sram1_dq_t}, 1);
    check("rst_dqt2", {31'd0, sram2_dq_t}, 1);
    check("rst_ack", {31'd0, ack}, 0);
    check("rst_data_o", {16'd0, data_o}, 0);
    check("rst_addr1", {14'd0, sram1_addr}, 0);
    check("rst_addr2", {14'd0, sram2_addr}, 0);
    rst = 1'b0; en = 1'b0;
    @(posedge clk_50MHz);
    @(negedge clk_50MHz);

    run_txn(0, 18'h00100, 16'hA5A5, 0);
    run_txn(1, 18'h00100, 16'h0000, 0);
    run_txn(1, 18'h09000, 16'h0000, 0);
    run_txn(2, 18'h0BF00, 16'h0041, 5);
    run_txn(4, 18'h0BF01, 16'h0000, 3'b110);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 5);
      idx  = 4'($urandom);
      k    = $urandom_range(0, 4);
      case (kind)
        0, 1:    a = $urandom_range(0, 1) ? {14'h0900, idx} : {14'h0000, idx};
        2, 3:    a = 18'h0BF00;
        default: begin a = 18'h0BF01; k = $urandom_range(0, 7); end
      endcase
      run_txn(kind, a, 16'($urandom), k);
    end

    // Reset in the middle of a bank-1 write strobe.
    en = 1'b1; op = 1'b1; addr = 18'h09003; data_i = 16'($urandom);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_50MHz);
      @(negedge clk_50MHz);
      if (!sram1_we_n) break;
    end
    check("abort_we_low", {31'd0, sram1_we_n}, 0);
    rst = 1'b1;
    @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    ref1[3] = data_i;
    check("abort_we1", {31'd0, sram1_we_n}, 1);
    check("abort_ce1", {31'd0, sram1_ce_n}, 1);
    check("abort_dqt1", {31'd0, sram1_dq_t}, 1);
    check("abort_ack", {31'd0, ack}, 0);
    rst = 1'b0; en = 1'b0;
    @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    check("abort_ack_after", {31'd0, ack}, 0);
    run_txn(4, 18'h0BF01, 16'h0000, $urandom_range(0, 7));
    run_txn(1, 18'h09003, 16'h0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
